// File: rtl/sample_tick_gen.sv
// rtl/sample_tick_gen.sv - multi-channel phase-accumulator sample tick generator
// Optional SAMPLE_TICK_COUNT_EN adds per-channel 16-bit wrapping tick counters on tick_count.
module sample_tick_gen #(
    parameter int NUM_CH       = 4,
    parameter int ACC_WIDTH    = 32,
    parameter int CLK_FREQ     = 100_000_000,
    parameter int DEFAULT_RATE = 16384
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [NUM_CH-1:0]        ch_en,
    input  logic                     sync_in,
    input  logic                     cfg_valid,
    input  logic [3:0]               cfg_ch,
    input  logic [ACC_WIDTH-1:0]     cfg_inc,
    output logic                     cfg_ready,
    output logic                     cfg_err,
    output logic [NUM_CH-1:0]        sample_tick
`ifdef SAMPLE_TICK_COUNT_EN
    ,
    output logic [NUM_CH*16-1:0]     tick_count
`endif
);

    localparam logic [127:0] DEF_NUM = 128'(DEFAULT_RATE) << ACC_WIDTH;
    localparam logic [ACC_WIDTH-1:0] DEFAULT_INC = ACC_WIDTH'(DEF_NUM / 128'(CLK_FREQ));

    typedef enum logic {
        S_IDLE,
        S_PENDING
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             pend_ch_q, pend_ch_d;
    logic [ACC_WIDTH-1:0]   pend_inc_q, pend_inc_d;
    logic                   err_q, err_d;
    logic [NUM_CH-1:0]      tick_q, tick_d;
    logic [ACC_WIDTH-1:0]   acc_q [NUM_CH];
    logic [ACC_WIDTH-1:0]   acc_d [NUM_CH];
    logic [ACC_WIDTH-1:0]   inc_q [NUM_CH];
    logic [ACC_WIDTH-1:0]   inc_d [NUM_CH];
    logic [ACC_WIDTH:0]     sum [NUM_CH];
    logic [NUM_CH-1:0]      carry;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_sum
        assign sum[g]   = {1'b0, acc_q[g]} + {1'b0, inc_q[g]};
        assign carry[g] = sum[g][ACC_WIDTH];
    end

    assign cfg_ready   = (state_q == S_IDLE);
    assign cfg_err     = err_q;
    assign sample_tick = tick_q;

    always_comb begin
        state_d    = state_q;
        pend_ch_d  = pend_ch_q;
        pend_inc_d = pend_inc_q;
        err_d      = 1'b0;
        tick_d     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            acc_d[i] = acc_q[i];
            inc_d[i] = inc_q[i];
            // sync wins over any carry: clear phase and swallow the tick
            if (sync_in) begin
                acc_d[i] = '0;
            end else if (ch_en[i]) begin
                acc_d[i]  = sum[i][ACC_WIDTH-1:0];
                tick_d[i] = carry[i];
            end
        end

        case (state_q)
            S_IDLE: begin
                if (cfg_valid) begin
                    if ({1'b0, cfg_ch} < 5'(NUM_CH)) begin
                        state_d    = S_PENDING;
                        pend_ch_d  = cfg_ch;
                        pend_inc_d = cfg_inc;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_PENDING: begin
                // load at a phase boundary so the rate change never glitches;
                // the accumulator keeps its remainder
                for (int i = 0; i < NUM_CH; i++) begin
                    if (pend_ch_q == 4'(i)) begin
                        if (sync_in || !ch_en[i] || carry[i]) begin
                            inc_d[i] = pend_inc_q;
                            state_d  = S_IDLE;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= S_IDLE;
            pend_ch_q  <= '0;
            pend_inc_q <= '0;
            err_q      <= 1'b0;
            tick_q     <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= '0;
                inc_q[i] <= DEFAULT_INC;
            end
        end else begin
            state_q    <= state_d;
            pend_ch_q  <= pend_ch_d;
            pend_inc_q <= pend_inc_d;
            err_q      <= err_d;
            tick_q     <= tick_d;
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= acc_d[i];
                inc_q[i] <= inc_d[i];
            end
        end
    end

`ifdef SAMPLE_TICK_COUNT_EN
    logic [15:0] cnt_q [NUM_CH];
    logic [15:0] cnt_d [NUM_CH];

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync_in) begin
                cnt_d[i] = '0;
            end else if (tick_q[i]) begin
                cnt_d[i] = cnt_q[i] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
        assign tick_count[g*16 +: 16] = cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_sample_tick_gen.sv
// tb/tb_sample_tick_gen.sv - scoreboard bench for sample_tick_gen with directed vectors
module tb_sample_tick_gen;
    localparam int NUM_CH = 4;
    localparam int W      = 32;
    localparam logic [W-1:0] INC_Q = 32'h4000_0000;
    localparam logic [W-1:0] INC_H = 32'h8000_0000;

    logic              clk_in = 1'b0;
    logic              rst_in = 1'b1;
    logic [NUM_CH-1:0] ch_en = '0;
    logic              sync_in = 1'b0;
    logic              cfg_valid = 1'b0;
    logic [3:0]        cfg_ch = '0;
    logic [W-1:0]      cfg_inc = '0;
    logic              cfg_ready;
    logic              cfg_err;
    logic [NUM_CH-1:0] sample_tick;
`ifdef SAMPLE_TICK_COUNT_EN
    logic [NUM_CH*16-1:0] tick_count;
`endif

    sample_tick_gen #(
        .NUM_CH(NUM_CH),
        .ACC_WIDTH(W),
        .CLK_FREQ(100_000_000),
        .DEFAULT_RATE(16384)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .ch_en(ch_en),
        .sync_in(sync_in),
        .cfg_valid(cfg_valid),
        .cfg_ch(cfg_ch),
        .cfg_inc(cfg_inc),
        .cfg_ready(cfg_ready),
        .cfg_err(cfg_err),
        .sample_tick(sample_tick)
`ifdef SAMPLE_TICK_COUNT_EN
        ,
        .tick_count(tick_count)
`endif
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        string      tag;
        int         step;
        logic [3:0] tick;
        logic       err;
        logic       rdy;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_bad = 0;

    // Expected outputs after the edge that ends the driven cycle.
    task automatic cyc(input string tag, input int step, input logic [3:0] en, input logic sync,
                       input logic v, input logic [3:0] ch, input logic [W-1:0] inc,
                       input logic [3:0] etick, input logic eerr, input logic erdy);
        exp_t e;
        @(negedge clk_in);
        ch_en     = en;
        sync_in   = sync;
        cfg_valid = v;
        cfg_ch    = ch;
        cfg_inc   = inc;
        e.tag  = tag;
        e.step = step;
        e.tick = etick;
        e.err  = eerr;
        e.rdy  = erdy;
        exp_q.push_back(e);
    endtask

    // Write with all channels disabled: pending one cycle, then loaded.
    task automatic wr(input logic [3:0] ch, input logic [W-1:0] inc);
        cyc("cfg_write", int'(ch), 4'h0, 1'b0, 1'b1, ch, inc, 4'h0, 1'b0, 1'b0);
        cyc("cfg_load", int'(ch), 4'h0, 1'b0, 1'b0, 4'h0, '0, 4'h0, 1'b0, 1'b1);
    endtask

    // ch0: 2^30 until switched to 2^31 at update 12; ch1: 2^30; ch2: 2^31; sync at 24.
    function automatic logic [3:0] pat(input int n);
        logic c0, c1, c2;
        if (n < 24) begin
            c0 = (n <= 12) ? (n % 4 == 0) : (n % 2 == 0);
            c1 = (n % 4 == 0);
            c2 = (n % 2 == 0);
        end else if (n == 24) begin
            c0 = 1'b0;
            c1 = 1'b0;
            c2 = 1'b0;
        end else begin
            c0 = ((n - 24) % 2 == 0);
            c1 = ((n - 24) % 4 == 0);
            c2 = c0;
        end
        return {1'b0, c2, c1, c0};
    endfunction

    always @(posedge clk_in) begin
        #2;
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            n_vec++;
            if (sample_tick !== mon_e.tick || cfg_err !== mon_e.err || cfg_ready !== mon_e.rdy) begin
                n_bad++;
                $display("FAIL %s step %0d: got tick=%b err=%b rdy=%b, want tick=%b err=%b rdy=%b",
                         mon_e.tag, mon_e.step, sample_tick, cfg_err, cfg_ready,
                         mon_e.tick, mon_e.err, mon_e.rdy);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish, %0d vectors %0d miscompares", n_vec, n_bad);
        $fatal(1);
    end

    initial begin
        cyc("reset", 0, 4'h0, 1'b0, 1'b0, 4'h0, '0, 4'h0, 1'b0, 1'b1);
        cyc("reset", 1, 4'hF, 1'b0, 1'b1, 4'h1, INC_H, 4'h0, 1'b0, 1'b1);
        @(negedge clk_in);
        ch_en     = '0;
        cfg_valid = 1'b0;
        rst_in    = 1'b0;

        // Default rate 703687: carries after updates 6104, 12208, 18311.
        cyc("default_sync", 0, 4'hF, 1'b1, 1'b0, 4'h0, '0, 4'h0, 1'b0, 1'b1);
        for (int n = 1; n <= 18311; n++) begin
            cyc("default_rate", n, 4'hF, 1'b0, 1'b0, 4'h0, '0,
                (n == 6104 || n == 12208 || n == 18311) ? 4'hF : 4'h0, 1'b0, 1'b1);
        end

        wr(4'd0, INC_Q);
        wr(4'd1, INC_Q);
        wr(4'd2, INC_H);
        cyc("cfg_err", 0, 4'h0, 1'b0, 1'b1, 4'd9, 32'h0000_1234, 4'h0, 1'b1, 1'b1);
        cyc("cfg_err_clr", 0, 4'h0, 1'b0, 1'b0, 4'd0, '0, 4'h0, 1'b0, 1'b1);

        cyc("pat_sync", 0, 4'hF, 1'b1, 1'b0, 4'h0, '0, 4'h0, 1'b0, 1'b1);
        for (int n = 1; n <= 34; n++) begin
            cyc("pattern", n, 4'hF, (n == 24), (n == 9 || n == 33),
                (n == 9) ? 4'd0 : 4'd3, INC_H, pat(n), 1'b0,
                !((n >= 9 && n <= 11) || n >= 33));
        end

        // Reset mid-pending on ch3: outputs must clear without a clock edge.
        @(negedge clk_in);
        #2;
        rst_in = 1'b1;
        #1;
        n_vec++;
        if (sample_tick !== 4'h0 || cfg_err !== 1'b0 || cfg_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL async_reset: got tick=%b err=%b rdy=%b, want tick=0000 err=0 rdy=1",
                     sample_tick, cfg_err, cfg_ready);
        end
        @(negedge clk_in);
        rst_in = 1'b0;

        // Lost write: ch3 must still run at the default rate, like the rest.
        cyc("post_reset_sync", 0, 4'hF, 1'b1, 1'b0, 4'h0, '0, 4'h0, 1'b0, 1'b1);
        for (int n = 1; n <= 6104; n++) begin
            cyc("post_reset_rate", n, 4'hF, 1'b0, 1'b0, 4'h0, '0,
                (n == 6104) ? 4'hF : 4'h0, 1'b0, 1'b1);
        end

        // ch0 at 2^30 with an enable gap; ch1 at increment 0 never ticks.
        wr(4'd0, INC_Q);
        wr(4'd1, '0);
        cyc("en_sync", 0, 4'h0, 1'b1, 1'b0, 4'h0, '0, 4'h0, 1'b0, 1'b1);
        for (int k = 0; k <= 10; k++) begin
            cyc("enable_hold", k, (k >= 3 && k <= 5) ? 4'h0 : 4'h3, 1'b0, 1'b0, 4'h0, '0,
                (k == 6 || k == 10) ? 4'h1 : 4'h0, 1'b0, 1'b1);
        end

        @(negedge clk_in);
        @(negedge clk_in);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
